// File: rtl/core_wb_arbiter.sv
// core_wb_arbiter: two-master (M0 = instruction fetch, M1 = data memory) to
// one-slave Wishbone classic arbiter. Round-robin grant, held for as long as
// the granted master keeps cyc high. A release hands the bus straight to a
// waiting master with no idle cycle in between.
// Optional watchdog: define CORE_WB_ARB_TIMEOUT_EN to error out a granted
// cycle that stalls for TIMEOUT_CYC strobed cycles without ack/err.
module core_wb_arbiter #(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            rst_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic [DW-1:0]   m_dat_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    output logic [1:0]      gnt_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_M0 = 2'd1,
        GNT_M1 = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last_gnt;       // 0: M0 was granted last, 1: M1
    logic   last_gnt_nxt;
    logic   tmo;            // watchdog fires in this cycle

`ifdef CORE_WB_ARB_TIMEOUT_EN
    localparam int unsigned CW = 16;
    logic [CW-1:0] tmo_cnt;

    assign tmo = (state != IDLE) && (tmo_cnt == CW'(TIMEOUT_CYC));

    // Stall counter: cleared by any grant change or slave response, counts strobed stall cycles
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt <= '0;
        end else if ((state_nxt != state) || s_ack_i || s_err_i || tmo) begin
            tmo_cnt <= '0;
        end else if (s_cyc_o && s_stb_o) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    localparam int unsigned TIMEOUT_UNUSED = TIMEOUT_CYC;
    assign tmo = 1'b0;
`endif

    // State and round-robin history registers
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            last_gnt <= 1'b0;
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
        end
    end

    // Next grant: round-robin from IDLE, hold while cyc, hand over directly on release
    always_comb begin
        state_nxt    = state;
        last_gnt_nxt = last_gnt;
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_nxt = last_gnt ? GNT_M0 : GNT_M1;
                end else if (m0_cyc_i) begin
                    state_nxt = GNT_M0;
                end else if (m1_cyc_i) begin
                    state_nxt = GNT_M1;
                end
            end
            GNT_M0: begin
                if (!m0_cyc_i || tmo) begin
                    last_gnt_nxt = 1'b0;
                    state_nxt    = m1_cyc_i ? GNT_M1 : IDLE;
                end
            end
            GNT_M1: begin
                if (!m1_cyc_i || tmo) begin
                    last_gnt_nxt = 1'b1;
                    state_nxt    = m0_cyc_i ? GNT_M0 : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Slave-side mux and response routing, purely from the registered state
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        gnt_o    = 2'b00;
        case (state)
            GNT_M0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i && !tmo;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i || tmo;
                gnt_o    = 2'b01;
            end
            GNT_M1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i && !tmo;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i || tmo;
                gnt_o    = 2'b10;
            end
            default: ;
        endcase
    end

    assign m_dat_o = s_dat_i;

endmodule

// File: tb/tb_core_wb_arbiter.sv
// Testbench for core_wb_arbiter: two random Wishbone masters and a random-latency
// slave, a scoreboard of issued beats, and a reference model of the grant rules.
module tb_core_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_cyc [2];
    logic        m_stb [2];
    logic        m_we  [2];
    logic [3:0]  m_sel [2];
    logic [31:0] m_adr [2];
    logic [31:0] m_dat [2];
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m_dat_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i, s_err_i;
    logic [1:0]  gnt_o;

    int checks = 0;
    int errors = 0;
    bit rand_done = 1'b0;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];

    always #5 clk = ~clk;

    core_wb_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYC(255)) dut (
        .clk(clk), .rst_i(rst),
        .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]),
        .m0_sel_i(m_sel[0]), .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]),
        .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]),
        .m1_sel_i(m_sel[1]), .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]),
        .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .m_dat_o(m_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .gnt_o(gnt_o)
    );

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] rd_model(logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic ack_of(int m);
        return (m == 0) ? m0_ack : m1_ack;
    endfunction

    function automatic logic err_of(int m);
        return (m == 0) ? m0_err : m1_err;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One master: random bus cycles of 1..3 beats separated by random idle gaps
    task automatic drive_master(input int m, input int ntx);
        beat_t b;
        int    nb;
        int    wc;
        for (int t = 0; t < ntx; t++) begin
            tick();
            if (t != 0) repeat ($urandom_range(0, 4)) tick();
            m_cyc[m] = 1'b1;
            nb = int'($urandom_range(1, 3));
            for (int k = 0; k < nb; k++) begin
                b.adr = 32'($urandom_range(0, 1023)) << 2;
                b.dat = $urandom;
                b.sel = 4'($urandom_range(1, 15));
                b.we  = 1'($urandom_range(0, 1));
                m_stb[m] = 1'b1;
                m_we[m]  = b.we;
                m_adr[m] = b.adr;
                m_dat[m] = b.dat;
                m_sel[m] = b.sel;
                if (m == 0) q0.push_back(b); else q1.push_back(b);
                wc = 0;
                do begin
                    @(negedge clk);
                    wc++;
                end while (!(ack_of(m) || err_of(m)) && wc < 200);
                if (!(ack_of(m) || err_of(m))) chk($sformatf("beat_done_m%0d", m), 0, 1);
                tick();
            end
            m_stb[m] = 1'b0;
            m_cyc[m] = 1'b0;
        end
    endtask

    // Slave: random response latency, occasional error, data derived from address
    task automatic slave_loop();
        while (!rand_done) begin
            @(posedge clk);
            #2;
            if (s_cyc_o && s_stb_o && $urandom_range(0, 2) != 0) begin
                if ($urandom_range(0, 9) == 0) begin
                    s_err_i = 1'b1; s_ack_i = 1'b0; s_dat_i = $urandom;
                end else begin
                    s_err_i = 1'b0; s_ack_i = 1'b1; s_dat_i = rd_model(s_adr_o);
                end
            end else begin
                s_ack_i = 1'b0; s_err_i = 1'b0; s_dat_i = $urandom;
            end
        end
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
    endtask

    // Monitor: grant model (owner 2 = nobody) plus routing and scoreboard checks
    task automatic monitor_loop();
        int    owner = 2;
        int    last  = 0;
        int    o;
        beat_t e;
        while (!rand_done) begin
            @(negedge clk);
            chk("gnt", gnt_o, (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00);
            chk("m_dat_bcast", m_dat_o, s_dat_i);
            if (owner == 2) begin
                chk("idle_s_cyc", s_cyc_o, 0);
                chk("idle_s_stb", s_stb_o, 0);
                chk("idle_resp", {m0_ack, m0_err, m1_ack, m1_err}, 0);
            end else begin
                o = owner;
                chk("s_cyc", s_cyc_o, m_cyc[o]);
                chk("s_stb", s_stb_o, m_stb[o]);
                chk("s_fields", {s_we_o, s_sel_o, s_adr_o, s_dat_o},
                    {m_we[o], m_sel[o], m_adr[o], m_dat[o]});
                chk("ack_route", {m0_ack, m1_ack}, (o == 0) ? {s_ack_i, 1'b0} : {1'b0, s_ack_i});
                chk("err_route", {m0_err, m1_err}, (o == 0) ? {s_err_i, 1'b0} : {1'b0, s_err_i});
                if (s_cyc_o && s_stb_o && (s_ack_i || s_err_i)) begin
                    if ((o == 0 ? q0.size() : q1.size()) == 0) begin
                        chk("sb_nonempty", 0, 1);
                    end else begin
                        e = (o == 0) ? q0.pop_front() : q1.pop_front();
                        chk("sb_beat", {s_we_o, s_sel_o, s_adr_o}, {e.we, e.sel, e.adr});
                        if (e.we) chk("sb_wdata", s_dat_o, e.dat);
                        else if (s_ack_i) chk("sb_rdata", m_dat_o, rd_model(e.adr));
                    end
                end
            end
            // grant for the next cycle, from this cycle's requests
            if (owner == 2) begin
                if (m_cyc[0] && m_cyc[1]) owner = 1 - last;
                else if (m_cyc[0])        owner = 0;
                else if (m_cyc[1])        owner = 1;
            end else if (!m_cyc[owner]) begin
                last  = owner;
                owner = m_cyc[1 - owner] ? 1 - owner : 2;
            end
        end
    endtask

    initial begin
        int wc;
        for (int i = 0; i < 2; i++) begin
            m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0;
            m_sel[i] = '0;   m_adr[i] = '0;   m_dat[i] = '0;
        end
        s_dat_i = 32'h1234_5678;
        s_ack_i = 1'b1;
        s_err_i = 1'b1;
        rst = 1'b1;
        #12;
        chk("reset_gnt", gnt_o, 2'b00);
        chk("reset_slave", {s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o}, 0);
        chk("reset_s_dat", s_dat_o, 0);
        chk("reset_resp", {m0_ack, m0_err, m1_ack, m1_err}, 0);
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        fork
            begin
                fork
                    drive_master(0, 40);
                    drive_master(1, 40);
                join
                repeat (4) @(posedge clk);
                rand_done = 1'b1;
            end
            slave_loop();
            monitor_loop();
            begin
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                chk("first_gnt_m1", gnt_o, 2'b10);
            end
        join
        chk("sb_drained", q0.size() + q1.size(), 0);

        // reset in the middle of an M1 write
        tick();
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
        m_adr[1] = 32'h40; m_sel[1] = 4'hF; m_dat[1] = 32'hCAFE_F00D;
        wc = 0;
        do begin
            @(negedge clk);
            wc++;
        end while (gnt_o != 2'b10 && wc < 10);
        chk("mid_gnt_m1", gnt_o, 2'b10);
        chk("mid_s_cyc", s_cyc_o, 1);
        s_ack_i = 1'b1;
        #1;
        chk("mid_m1_ack", m1_ack, 1);
        rst = 1'b1;
        #1;
        chk("rst_async_cyc", {s_cyc_o, s_stb_o}, 0);
        chk("rst_async_gnt", gnt_o, 2'b00);
        chk("rst_async_ack", m1_ack, 0);
        chk("rst_async_bus", {s_adr_o, s_dat_o}, 0);
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_we[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // slave response while idle goes nowhere
        s_err_i = 1'b1;
        tick();
        @(negedge clk);
        chk("idle_ack_dropped", {m0_ack, m0_err, m1_ack, m1_err}, 0);
        s_ack_i = 1'b0;
        s_err_i = 1'b0;

        // round-robin alternation after reset
        tick();
        m_cyc[0] = 1'b1; m_cyc[1] = 1'b1;
        @(negedge clk);
        chk("alt_req_cycle", gnt_o, 2'b00);
        tick();
        m_cyc[1] = 1'b0;
        @(negedge clk);
        chk("alt_m1_first", gnt_o, 2'b10);
        tick();
        m_cyc[0] = 1'b0;
        @(negedge clk);
        chk("alt_no_bubble_m0", gnt_o, 2'b01);
        tick();
        m_cyc[0] = 1'b1; m_cyc[1] = 1'b1;
        @(negedge clk);
        chk("alt_idle", gnt_o, 2'b00);
        tick();
        m_cyc[0] = 1'b0; m_cyc[1] = 1'b0;
        @(negedge clk);
        chk("alt_m1_again", gnt_o, 2'b10);
        tick();
        tick();
        @(negedge clk);
        chk("alt_final_idle", gnt_o, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_wb_arbiter.md
Name: core_wb_arbiter

Overview:
Two-master to one-slave Wishbone classic arbiter. It lets the core's instruction-fetch port (M0) and data-memory port (M1) share a single memory/interconnect slave port.
- Grant is round-robin and held for the whole bus cycle, i.e. for as long as the granted master keeps cyc high.
- Sits between the core top level and the single-ported memory in single-port SoC builds.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT_CYC, 255, stall cycles before watchdog error (used only with optional feature)

Ports:
clk  in  1  system clock
rst_i  in  1  reset, asynchronous, active-high
m0_cyc_i  in  1  M0 (IF) bus cycle
m0_stb_i  in  1  M0 strobe
m0_we_i  in  1  M0 write enable
m0_sel_i  in  DW/8  M0 byte select
m0_adr_i  in  AW  M0 address
m0_dat_i  in  DW  M0 write data
m0_ack_o  out  1  M0 acknowledge
m0_err_o  out  1  M0 error
m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i  in  as M0  M1 (MEM) request signals
m1_ack_o  out  1  M1 acknowledge
m1_err_o  out  1  M1 error
m_dat_o  out  DW  read data, broadcast to both masters
s_cyc_o  out  1  slave cycle
s_stb_o  out  1  slave strobe
s_we_o  out  1  slave write enable
s_sel_o  out  DW/8  slave byte select
s_adr_o  out  AW  slave address
s_dat_o  out  DW  slave write data
s_dat_i  in  DW  slave read data
s_ack_i  in  1  slave acknowledge
s_err_i  in  1  slave error
gnt_o  out  2  one-hot current grant (debug/perf)

Behaviour:
- One clock domain (clk). rst_i is asynchronous, active-high.
- Reset state: state=IDLE, last_gnt=M0, gnt_o=00, s_cyc_o=s_stb_o=s_we_o=0, s_sel_o/s_adr_o/s_dat_o=0, all ack/err outputs=0.
- State machine: IDLE, GNT_M0, GNT_M1. Registered state; slave-side mux is combinational from the state.
- IDLE:
  - Only m0_cyc_i high -> GNT_M0.
  - Only m1_cyc_i high -> GNT_M1.
  - Both high -> grant the master that is not last_gnt. After reset this is M1.
  - Neither high -> stay IDLE.
- Arbitration latency: one cycle. A request raised in cycle n appears on the slave in cycle n+1.
- GNT_Mx:
  - s_* outputs = Mx's signals; s_cyc_o=mx_cyc_i; s_stb_o=mx_stb_i.
  - mx_ack_o=s_ack_i and mx_err_o=s_err_i. The other master's ack/err is forced 0.
  - Grant is held while mx_cyc_i=1, so multi-beat/back-to-back cycles are not interrupted.
- Release: on the edge where mx_cyc_i=0, last_gnt<=Mx.
  - Other master's cyc high -> next state is GNT_other directly, with no idle bubble.
  - Otherwise -> IDLE.
- In IDLE, all s_* outputs are driven 0 and no ack/err reaches any master.
- m_dat_o=s_dat_i at all times. Masters qualify it with their own ack.
- gnt_o: 01 in GNT_M0, 10 in GNT_M1, 00 in IDLE.
- Reset mid-transaction: s_cyc_o drops asynchronously and no ack is forwarded.
- A slave ack arriving in IDLE is discarded.
- An ack and a cyc deassertion in the same cycle is legal; release still occurs at that edge.

Optional Feature:
Macro CORE_WB_ARB_TIMEOUT_EN.
- Enabled:
  - An 8..16-bit counter clears on every grant change and on every s_ack_i/s_err_i.
  - It increments each cycle with s_cyc_o&s_stb_o=1 and no ack/err.
  - When the count reaches TIMEOUT_CYC, the arbiter asserts mx_err_o to the granted master for exactly one cycle and holds s_stb_o=0 in that cycle.
  - On the next edge it clears the counter, sets last_gnt=Mx and goes to IDLE, or directly to GNT_other if the other master is requesting.
- Disabled: no counter; err outputs are a pure pass-through of s_err_i.

Test Plan:
- Reset: assert rst_i mid-GNT_M1 write -> s_cyc_o=0 immediately; gnt_o=00; no m1_ack_o.
- Single M0 read adr=0x100: m0_cyc/stb at cycle 0 -> s_adr_o=0x100 and gnt_o=01 at cycle 1; slave acks with 0xDEADBEEF at cycle 2 -> m0_ack_o=1, m_dat_o=0xDEADBEEF, m1_ack_o=0.
- Simultaneous requests after reset -> M1 granted first. M1 drops cyc -> M0 granted on the next cycle with no IDLE bubble. Then both request again -> M1 granted (alternation).
- Held grant: M1 keeps cyc high over 3 back-to-back acked writes (adr 0x0/0x4/0x8, sel=0xF) while M0 requests -> M0 is not granted until M1 drops cyc; all 3 writes seen on slave in order.
- Slave error: s_err_i=1 during M0 cycle -> m0_err_o=1 for the same cycle, m1_err_o=0.
- With CORE_WB_ARB_TIMEOUT_EN, TIMEOUT_CYC=4: slave never acks an M1 read -> m1_err_o pulses exactly once after 4 stalled cycles, then the arbiter returns to IDLE (or grants a pending M0).
